// File: rtl/serial_adder_arbiter.sv
// serial_adder_arbiter
//   Bit-serial adder that two requesters share through a round-robin arbiter.
//   One full adder, built from two chained half adders, processes one bit per
//   cycle, LSB first, over WIDTH cycles. Operands are captured at grant, and the
//   result is delivered with a one-cycle done pulse.
//
//   Optional build macro: OVERFLOW_FLAG_EN
//     When it is defined, the block adds an 'overflow' output that holds the
//     two's-complement signed overflow of the last completed add.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_0/1    level add requests, held until the matching grant
//   a_0/b_0    requester 0 operands, sampled at grant
//   a_1/b_1    requester 1 operands, sampled at grant
//   gnt_0/1    one-cycle pulse, high once that requester's operands are captured
//   busy       operation in flight (registered, lags state by one cycle)
//   done       one-cycle pulse, high when sum/carry_out are valid
//   done_id    index of the requester whose add just completed
//   sum        result modulo 2^WIDTH, held until the next done
//   carry_out  carry out of the MSB, held with sum
//   overflow   (OVERFLOW_FLAG_EN only) signed overflow, held with sum
//
// States:
//   IDLE  | arbitrate and capture operands on grant
//   SHIFT | add one bit per cycle, WIDTH cycles in total
//   DONE  | publish sum/carry_out and pulse done

module serial_adder_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_0,
  input  logic [WIDTH-1:0] a_0,
  input  logic [WIDTH-1:0] b_0,
  input  logic             req_1,
  input  logic [WIDTH-1:0] a_1,
  input  logic [WIDTH-1:0] b_1,
  output logic             gnt_0,
  output logic             gnt_1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last_served;
  logic             cur_id;
`ifdef OVERFLOW_FLAG_EN
  logic             carry_msb_in;
`endif

  logic ha1_s, ha1_c, ha2_s, ha2_c, carry_next;

  assign ha1_s      = a_sr[0] ^ b_sr[0];
  assign ha1_c      = a_sr[0] & b_sr[0];
  assign ha2_s      = ha1_s ^ carry;
  assign ha2_c      = ha1_s & carry;
  assign carry_next = ha1_c | ha2_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      gnt_0        <= 1'b0;
      gnt_1        <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      done_id      <= 1'b0;
      sum          <= '0;
      carry_out    <= 1'b0;
      a_sr         <= '0;
      b_sr         <= '0;
      acc          <= '0;
      carry        <= 1'b0;
      cnt          <= '0;
      last_served  <= 1'b1;
      cur_id       <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      carry_msb_in <= 1'b0;
      overflow     <= 1'b0;
`endif
    end else begin
      gnt_0 <= 1'b0;
      gnt_1 <= 1'b0;
      done  <= 1'b0;
      busy  <= (state != IDLE);
      case (state)
        IDLE: begin
          // On a tie, requester 0 wins when requester 1 was the last one served.
          if (req_0 && (!req_1 || last_served)) begin
            gnt_0       <= 1'b1;
            a_sr        <= a_0;
            b_sr        <= b_0;
            acc         <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            cur_id      <= 1'b0;
            last_served <= 1'b0;
            state       <= SHIFT;
          end else if (req_1) begin
            gnt_1       <= 1'b1;
            a_sr        <= a_1;
            b_sr        <= b_1;
            acc         <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            cur_id      <= 1'b1;
            last_served <= 1'b1;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          acc   <= {ha2_s, acc[WIDTH-1:1]};
          carry <= carry_next;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
`ifdef OVERFLOW_FLAG_EN
            carry_msb_in <= carry;
`endif
            state <= DONE;
          end
        end
        DONE: begin
          sum       <= acc;
          carry_out <= carry;
          done      <= 1'b1;
          done_id   <= cur_id;
`ifdef OVERFLOW_FLAG_EN
          overflow  <= carry_msb_in ^ carry;
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
